// File: rtl/proc_pkg.sv
// Shared processor constants: phase codes and sequencer state encoding.
// The control decoder imports the same definitions.
package proc_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE = 3'd0,
    PH_IF   = 3'd1,
    PH_ID   = 3'd2,
    PH_EX   = 3'd3,
    PH_MEM  = 3'd4,
    PH_WB   = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  // Advance to the following pipeline phase (caller handles the WB wrap)
  function automatic phase_e next_phase(input phase_e p);
    return phase_e'(PHASE_W'(p + 3'd1));
  endfunction

  // Phases in which a decoded HLT is trusted
  function automatic logic halt_window(input phase_e p);
    return (p == PH_ID) || (p == PH_EX) || (p == PH_MEM) || (p == PH_WB);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Button, decoder and status signals between the phase sequencer and its surroundings.
interface phase_sequencer_if;
  import proc_pkg::*;

  logic               exec;
  logic               step;
  logic               stop_flag;
  logic [PHASE_W-1:0] phase;
  logic               running;
  logic               halted;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    output exec, step, stop_flag,
    input  phase, running, halted, instr_count
  );

  modport slave (
    input  exec, step, stop_flag,
    output phase, running, halted, instr_count
  );

endinterface

// File: rtl/btn_pulse.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous button.
// The pulse is registered, so it appears 3 cycles after the button rises.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with run/stop, single-step and HLT handling.
// Counts completed WB phases; HALTED is left only through reset.
module phase_sequencer
  import proc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  logic exec_pulse;
  logic step_pulse;

  btn_pulse u_exec_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.exec),
    .pulse (exec_pulse)
  );

  btn_pulse u_step_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.step),
    .pulse (step_pulse)
  );

  seq_state_e         state_q,     state_d;
  phase_e             phase_q,     phase_d;
  logic               halt_pend_q, halt_pend_d;
  logic               stop_pend_q, stop_pend_d;
  logic               running_q,   running_d;
  logic               halted_q,    halted_d;
  logic [COUNT_W-1:0] count_q,     count_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_IDLE;
      halt_pend_q <= 1'b0;
      stop_pend_q <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      halt_pend_q <= halt_pend_d;
      stop_pend_q <= stop_pend_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      count_q     <= count_d;
    end
  end

  // Next state; pending flags raised in phase WB still steer the WB exit
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    halt_pend_d = halt_pend_q;
    stop_pend_d = stop_pend_q;
    count_d     = count_q;

    case (state_q)
      ST_IDLE: begin
        if (exec_pulse) begin
          state_d     = ST_RUN;
          phase_d     = PH_IF;
          halt_pend_d = 1'b0;
        end else if (step_pulse) begin
          state_d     = ST_STEP;
          phase_d     = PH_IF;
          halt_pend_d = 1'b0;
        end
      end

      ST_RUN, ST_STEP: begin
        if (bus.stop_flag && halt_window(phase_q)) begin
          halt_pend_d = 1'b1;
        end
        if ((state_q == ST_RUN) && exec_pulse) begin
          stop_pend_d = 1'b1;
        end

        if (phase_q != PH_WB) begin
          phase_d = next_phase(phase_q);
        end else begin
          count_d = count_q + COUNT_W'(1);
          if (halt_pend_d) begin
            state_d     = ST_HALTED;
            phase_d     = PH_IDLE;
            stop_pend_d = 1'b0;
          end else if ((state_q == ST_STEP) || stop_pend_d) begin
            state_d     = ST_IDLE;
            phase_d     = PH_IDLE;
            stop_pend_d = 1'b0;
          end else begin
            phase_d     = PH_IF;
            halt_pend_d = 1'b0;
          end
        end
      end

      ST_HALTED: begin
        phase_d = PH_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    halted_d  = (state_d == ST_HALTED);
  end

  assign bus.phase       = phase_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: run, stop, step, halt, reset and counter wrap.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  phase_sequencer_if bus ();

  phase_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd0) $display("FAIL reset_phase got %0d want 0", bus.phase); else passes++;
    checks++; if (bus.running !== 1'b0) $display("FAIL reset_running got %b want 0", bus.running); else passes++;
    checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b want 0", bus.halted); else passes++;
    checks++; if (bus.instr_count !== 16'h0000) $display("FAIL reset_count got %h want 0000", bus.instr_count); else passes++;
    rst = 1'b1;
    tick(1);
    checks++; if (bus.phase !== 3'd0) $display("FAIL post_reset_phase got %0d want 0", bus.phase); else passes++;
  endtask

  task automatic test_run();
    bus.exec = 1'b1;
    tick(2);
    bus.exec = 1'b0;
    tick(1);
    checks++; if (bus.phase !== 3'd0) $display("FAIL run_latency_early got %0d want 0", bus.phase); else passes++;
    tick(1);
    checks++; if (bus.running !== 1'b1) $display("FAIL run_running got %b want 1", bus.running); else passes++;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick(1);
      checks++;
      if (bus.phase !== 3'((i % 5) + 1))
        $display("FAIL run_phase[%0d] got %0d want %0d", i, bus.phase, (i % 5) + 1);
      else passes++;
      checks++;
      if (bus.instr_count !== 16'(i / 5))
        $display("FAIL run_count[%0d] got %0d want %0d", i, bus.instr_count, i / 5);
      else passes++;
    end
  endtask

  task automatic test_stop_in_run();
    int exp_ph[6] = '{1, 2, 3, 4, 5, 0};
    tick(4);
    checks++; if (bus.phase !== 3'd5) $display("FAIL stop_setup_phase got %0d want 5", bus.phase); else passes++;
    bus.exec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (i == 1) bus.exec = 1'b0;
      checks++;
      if (bus.phase !== 3'(exp_ph[i]))
        $display("FAIL stop_phase[%0d] got %0d want %0d", i, bus.phase, exp_ph[i]);
      else passes++;
    end
    checks++; if (bus.running !== 1'b0) $display("FAIL stop_running got %b want 0", bus.running); else passes++;
    checks++; if (bus.instr_count !== 16'd5) $display("FAIL stop_count got %0d want 5", bus.instr_count); else passes++;
    tick(5);
    checks++; if (bus.phase !== 3'd0) $display("FAIL stop_stays_idle got %0d want 0", bus.phase); else passes++;
  endtask

  task automatic test_step();
    int exp_ph[5] = '{2, 3, 4, 5, 0};
    bus.step = 1'b1;
    tick(2);
    bus.step = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd1) $display("FAIL step_start_phase got %0d want 1", bus.phase); else passes++;
    checks++; if (bus.running !== 1'b1) $display("FAIL step_running got %b want 1", bus.running); else passes++;
    bus.step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 1) bus.step = 1'b0;
      checks++;
      if (bus.phase !== 3'(exp_ph[i]))
        $display("FAIL step_phase[%0d] got %0d want %0d", i, bus.phase, exp_ph[i]);
      else passes++;
    end
    checks++; if (bus.instr_count !== 16'd6) $display("FAIL step_count got %0d want 6", bus.instr_count); else passes++;
    checks++; if (bus.running !== 1'b0) $display("FAIL step_end_running got %b want 0", bus.running); else passes++;
    tick(6);
    checks++; if (bus.phase !== 3'd0) $display("FAIL step_second_ignored got %0d want 0", bus.phase); else passes++;
    checks++; if (bus.instr_count !== 16'd6) $display("FAIL step_count_hold got %0d want 6", bus.instr_count); else passes++;
  endtask

  task automatic test_same_cycle();
    bus.exec = 1'b1;
    bus.step = 1'b1;
    tick(2);
    bus.exec = 1'b0;
    bus.step = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd1) $display("FAIL both_start_phase got %0d want 1", bus.phase); else passes++;
    tick(5);
    checks++; if (bus.phase !== 3'd1) $display("FAIL both_run_wins got %0d want 1", bus.phase); else passes++;
    checks++; if (bus.running !== 1'b1) $display("FAIL both_running got %b want 1", bus.running); else passes++;
  endtask

  task automatic test_reset_mid();
    tick(2);
    checks++; if (bus.phase !== 3'd3) $display("FAIL mid_setup_phase got %0d want 3", bus.phase); else passes++;
    rst = 1'b0;
    tick(1);
    checks++; if (bus.phase !== 3'd0) $display("FAIL mid_reset_phase got %0d want 0", bus.phase); else passes++;
    checks++; if (bus.instr_count !== 16'd0) $display("FAIL mid_reset_count got %0d want 0", bus.instr_count); else passes++;
    checks++; if (bus.halted !== 1'b0) $display("FAIL mid_reset_halted got %b want 0", bus.halted); else passes++;
    checks++; if (bus.running !== 1'b0) $display("FAIL mid_reset_running got %b want 0", bus.running); else passes++;
    rst = 1'b1;
    tick(1);
    checks++; if (bus.phase !== 3'd0) $display("FAIL mid_release_phase got %0d want 0", bus.phase); else passes++;
  endtask

  task automatic test_halt();
    bus.exec = 1'b1;
    tick(2);
    bus.exec = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd1) $display("FAIL halt_start_phase got %0d want 1", bus.phase); else passes++;
    tick(15);
    checks++; if (bus.instr_count !== 16'd3) $display("FAIL halt_count3 got %0d want 3", bus.instr_count); else passes++;
    tick(1);
    checks++; if (bus.phase !== 3'd2) $display("FAIL halt_ph2 got %0d want 2", bus.phase); else passes++;
    bus.stop_flag = 1'b1;
    tick(1);
    bus.stop_flag = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd5) $display("FAIL halt_completes got %0d want 5", bus.phase); else passes++;
    tick(1);
    checks++; if (bus.halted !== 1'b1) $display("FAIL halt_halted got %b want 1", bus.halted); else passes++;
    checks++; if (bus.phase !== 3'd0) $display("FAIL halt_phase got %0d want 0", bus.phase); else passes++;
    checks++; if (bus.instr_count !== 16'd4) $display("FAIL halt_count got %0d want 4", bus.instr_count); else passes++;
    checks++; if (bus.running !== 1'b0) $display("FAIL halt_running got %b want 0", bus.running); else passes++;
    bus.exec = 1'b1;
    bus.step = 1'b1;
    tick(2);
    bus.exec = 1'b0;
    bus.step = 1'b0;
    tick(8);
    checks++; if (bus.halted !== 1'b1) $display("FAIL halt_sticky got %b want 1", bus.halted); else passes++;
    checks++; if (bus.phase !== 3'd0) $display("FAIL halt_sticky_phase got %0d want 0", bus.phase); else passes++;
    checks++; if (bus.instr_count !== 16'd4) $display("FAIL halt_sticky_count got %0d want 4", bus.instr_count); else passes++;
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    tick(1);
    checks++; if (bus.halted !== 1'b0) $display("FAIL wrap_reset_halted got %b want 0", bus.halted); else passes++;
    rst = 1'b1;
    tick(1);
    force dut.count_q = 16'hFFFF;
    tick(1);
    release dut.count_q;
    checks++; if (bus.instr_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", bus.instr_count); else passes++;
    bus.step = 1'b1;
    tick(2);
    bus.step = 1'b0;
    tick(2);
    checks++; if (bus.phase !== 3'd1) $display("FAIL wrap_start_phase got %0d want 1", bus.phase); else passes++;
    tick(4);
    checks++; if (bus.instr_count !== 16'hFFFF) $display("FAIL wrap_pre_wb got %h want ffff", bus.instr_count); else passes++;
    tick(1);
    checks++; if (bus.instr_count !== 16'h0000) $display("FAIL wrap_count got %h want 0000", bus.instr_count); else passes++;
    checks++; if (bus.phase !== 3'd0) $display("FAIL wrap_end_phase got %0d want 0", bus.phase); else passes++;
  endtask

  initial begin
    rst           = 1'b0;
    bus.exec      = 1'b0;
    bus.step      = 1'b0;
    bus.stop_flag = 1'b0;
    test_reset();
    test_run();
    test_stop_in_run();
    test_step();
    test_same_cycle();
    test_reset_mid();
    test_halt();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
